// File: rtl/cardinal_router_port.sv
// Two-VC router port: one-flit ingress and egress buffer per VC, alternated by
// polarity so each buffer is filled on one phase and drained on the opposite one.
module cardinal_router_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        nic_so,
  output logic        nic_ro,
  input  logic [63:0] nic_do,
  output logic        nic_si,
  input  logic        nic_ri,
  output logic [63:0] nic_di,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        proto_err
);

  logic [63:0] ibuf_data [2];
  logic [63:0] ebuf_data [2];
  logic [1:0]  ibuf_full;
  logic [1:0]  ebuf_full;

  logic ext_vc;
  logic int_vc;
  logic in_vc;
  logic nic_acc;
  logic nic_bad;
  logic nic_send;
  logic out_fire;
  logic in_fire;

  assign ext_vc = polarity;
  assign int_vc = ~polarity;
  assign in_vc  = in_data[0];

  // NIC side always works on the external-phase VC
  assign nic_ro   = ~ibuf_full[ext_vc] & ~reset;
  assign nic_acc  = nic_so & nic_ro & (nic_do[0] == ext_vc);
  assign nic_bad  = nic_so & ~nic_acc;
  assign nic_send = ebuf_full[ext_vc] & nic_ri;

  // Fabric side always works on the internal-phase VC
  assign out_valid = ibuf_full[int_vc];
  assign out_data  = ibuf_data[int_vc];
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = ~ebuf_full[in_vc] & (in_vc != polarity);
  assign in_fire   = in_valid & in_ready;

  // Ingress: NIC -> ibuf -> fabric; illegal NIC sends are dropped and flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibuf_full    <= 2'b00;
      ibuf_data[0] <= 64'd0;
      ibuf_data[1] <= 64'd0;
      proto_err    <= 1'b0;
    end else begin
      if (nic_acc) begin
        ibuf_full[ext_vc] <= 1'b1;
        ibuf_data[ext_vc] <= nic_do;
      end
      if (out_fire) begin
        ibuf_full[int_vc] <= 1'b0;
      end
      if (nic_bad) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Egress: fabric -> ebuf -> registered NIC send; load and send never share a VC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ebuf_full    <= 2'b00;
      ebuf_data[0] <= 64'd0;
      ebuf_data[1] <= 64'd0;
      nic_si       <= 1'b0;
      nic_di       <= 64'd0;
    end else begin
      if (in_fire) begin
        ebuf_full[in_vc] <= 1'b1;
        ebuf_data[in_vc] <= in_data;
      end
      nic_si <= nic_send;
      if (nic_send) begin
        ebuf_full[ext_vc] <= 1'b0;
        nic_di            <= ebuf_data[ext_vc];
      end
    end
  end

endmodule

// File: tb/tb_cardinal_router_port.sv
// Randomized self-checking bench for cardinal_router_port with a queue-based
// per-VC reference model and payload-ordering scoreboards.
module tb_cardinal_router_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        polarity = 1'b0;
  logic        nic_so = 1'b0;
  logic        nic_ri = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] nic_do = 64'd0;
  logic [63:0] in_data = 64'd0;
  logic        nic_ro, nic_si, out_valid, in_ready, proto_err;
  logic [63:0] nic_di, out_data;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: one queue per VC and direction (depth never exceeds 1)
  logic [63:0] iq [2][$];
  logic [63:0] eq [2][$];
  logic        exp_si;
  logic        exp_perr;
  logic [63:0] exp_di;

  cardinal_router_port dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .nic_so(nic_so), .nic_ro(nic_ro), .nic_do(nic_do),
    .nic_si(nic_si), .nic_ri(nic_ri), .nic_di(nic_di),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) polarity <= 1'b0;
    else       polarity <= ~polarity;
  end

  function automatic logic m_ro();
    return (iq[polarity].size() == 0);
  endfunction

  function automatic logic m_ir();
    return (eq[in_data[0]].size() == 0) && (in_data[0] != polarity);
  endfunction

  task automatic model_reset();
    iq[0].delete(); iq[1].delete();
    eq[0].delete(); eq[1].delete();
    exp_si = 1'b0; exp_di = 64'd0; exp_perr = 1'b0;
  endtask

  // Apply the port rules to the current inputs as of the coming rising edge
  task automatic model_edge();
    logic p, ro, ir;
    logic [63:0] tmp;
    p  = polarity;
    ro = m_ro();
    ir = m_ir();
    if (iq[!p].size() != 0 && out_ready) tmp = iq[!p].pop_front();
    if (nic_so) begin
      if (ro && nic_do[0] == p) iq[p].push_back(nic_do);
      else exp_perr = 1'b1;
    end
    if (in_valid && ir) eq[in_data[0]].push_back(in_data);
    if (eq[p].size() != 0 && nic_ri) begin
      exp_si = 1'b1;
      exp_di = eq[p].pop_front();
    end else begin
      exp_si = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    nic_so = 1'b0; in_valid = 1'b0; out_ready = 1'b0; nic_ri = 1'b0;
    nic_do = 64'd0; in_data = 64'd0;
  endtask

  task automatic apply_reset(input int cycles);
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset = 1'b1;
    model_reset();
    repeat (7) begin
      @(posedge clk); #1;
      n_chk++;
      if (nic_ro !== 1'b0) begin n_fail++; $display("FAIL reset_hold_nic_ro: got %b want 0", nic_ro); end
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_out_valid: got %b want 0", out_valid); end
    end
    reset = 1'b0;
    #1;
    n_chk++;
    if (nic_ro !== 1'b1) begin n_fail++; $display("FAIL reset_nic_ro: got %b want 1", nic_ro); end
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++;
    if (nic_si !== 1'b0) begin n_fail++; $display("FAIL reset_nic_si: got %b want 0", nic_si); end
    n_chk++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    n_chk++;
    if (nic_di !== 64'd0) begin n_fail++; $display("FAIL reset_nic_di: got %h want 0", nic_di); end
  endtask

  task automatic test_ingress_stream(input int n);
    int tx, rx, cyc;
    tx = 0; rx = 0; cyc = 0;
    apply_reset(2);
    out_ready = 1'b1; nic_ri = 1'b1;
    while (rx < n && cyc < 4 * n) begin
      nic_so = 1'b0;
      if (tx < n && m_ro() && $urandom_range(0, 9) != 0) begin
        nic_so = 1'b1;
        nic_do = {tx[31:0], 31'($urandom), polarity};
        tx++;
      end
      #1;
      n_chk++;
      if (nic_ro !== m_ro()) begin n_fail++; $display("FAIL ing_nic_ro: got %b want %b", nic_ro, m_ro()); end
      n_chk++;
      if (out_valid !== (iq[!polarity].size() != 0)) begin
        n_fail++; $display("FAIL ing_out_valid: got %b want %b", out_valid, iq[!polarity].size() != 0);
      end
      if (out_valid === 1'b1) begin
        n_chk++;
        if (out_data[63:32] !== rx[31:0]) begin
          n_fail++; $display("FAIL ing_order: got %0d want %0d", out_data[63:32], rx);
        end
        rx++;
      end
      tick();
      cyc++;
    end
    nic_so = 1'b0;
    n_chk++;
    if (rx != n) begin n_fail++; $display("FAIL ing_count: got %0d want %0d", rx, n); end
    n_chk++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL ing_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_ingress_stall();
    int seen;
    apply_reset(2);
    nic_ri = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nic_so = 1'b1;
      nic_do = {32'hA000 + 32'(polarity), 31'd0, polarity};
      #1;
      n_chk++;
      if (nic_ro !== 1'b1) begin n_fail++; $display("FAIL stall_fill_ro: got %b want 1", nic_ro); end
      tick();
    end
    nic_so = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++;
      if (nic_ro !== 1'b0) begin n_fail++; $display("FAIL stall_nic_ro: got %b want 0", nic_ro); end
      n_chk++;
      if (out_data[63:32] !== 32'hA000 + 32'(!polarity)) begin
        n_fail++; $display("FAIL stall_out_data: got %h want %h", out_data[63:32], 32'hA000 + 32'(!polarity));
      end
      tick();
    end
    nic_so = 1'b1;
    nic_do = {32'hDEAD, 31'd0, polarity};
    tick();
    nic_so = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if (proto_err !== 1'b1) begin n_fail++; $display("FAIL stall_proto_err: got %b want 1", proto_err); end
      n_chk++;
      if (out_data[63:32] !== 32'hA000 + 32'(!polarity)) begin
        n_fail++; $display("FAIL stall_out_kept: got %h want %h", out_data[63:32], 32'hA000 + 32'(!polarity));
      end
      tick();
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        n_chk++;
        if (out_data[63:32] !== 32'hA000 + 32'(!polarity)) begin
          n_fail++; $display("FAIL stall_drain_data: got %h want %h", out_data[63:32], 32'hA000 + 32'(!polarity));
        end
        seen++;
      end
      tick();
    end
    n_chk++;
    if (seen != 2) begin n_fail++; $display("FAIL stall_drain_count: got %0d want 2", seen); end
  endtask

  task automatic test_vc_mismatch();
    apply_reset(2);
    out_ready = 1'b1;
    nic_so = 1'b1;
    nic_do = {32'hBEEF, 31'd0, !polarity};
    tick();
    nic_so = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (proto_err !== 1'b1) begin n_fail++; $display("FAIL vcmis_proto_err: got %b want 1", proto_err); end
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vcmis_dropped: got %b want 0", out_valid); end
      tick();
    end
  endtask

  task automatic test_egress_stream(input int n);
    int tx, rx, cyc;
    logic ir;
    tx = 0; rx = 0; cyc = 0;
    apply_reset(2);
    nic_ri = 1'b1; out_ready = 1'b1;
    while (rx < n && cyc < 4 * n) begin
      in_valid = (tx < n) && ($urandom_range(0, 3) != 0);
      in_data  = {tx[31:0], 31'($urandom), tx[0]};
      #1;
      ir = m_ir();
      n_chk++;
      if (in_ready !== ir) begin n_fail++; $display("FAIL egr_in_ready: got %b want %b", in_ready, ir); end
      n_chk++;
      if (nic_si !== exp_si) begin n_fail++; $display("FAIL egr_nic_si: got %b want %b", nic_si, exp_si); end
      if (nic_si === 1'b1) begin
        n_chk++;
        if (nic_di[63:32] !== rx[31:0]) begin
          n_fail++; $display("FAIL egr_order: got %0d want %0d", nic_di[63:32], rx);
        end
        n_chk++;
        if (nic_di[0] !== !polarity) begin
          n_fail++; $display("FAIL egr_vc_phase: got %b want %b", nic_di[0], !polarity);
        end
        rx++;
      end
      if (in_valid && ir) tx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (rx != n) begin n_fail++; $display("FAIL egr_count: got %0d want %0d", rx, n); end
  endtask

  task automatic test_nic_backpressure();
    apply_reset(2);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = {32'hB000 + 32'(k), 31'd0, !polarity};
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready: got %b want 1", in_ready); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_data  = {32'hC000, 31'd0, !polarity};
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      n_chk++;
      if (nic_si !== 1'b0) begin n_fail++; $display("FAIL bp_nic_si: got %b want 0", nic_si); end
      tick();
    end
    in_valid = 1'b0;
    nic_ri = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if (nic_si !== 1'b1) begin n_fail++; $display("FAIL bp_release_si: got %b want 1", nic_si); end
      n_chk++;
      if (nic_di[63:32] !== 32'hB000 + 32'(polarity)) begin
        n_fail++; $display("FAIL bp_release_data: got %h want %h", nic_di[63:32], 32'hB000 + 32'(polarity));
      end
      tick();
    end
    #1;
    n_chk++;
    if (nic_si !== 1'b0) begin n_fail++; $display("FAIL bp_after_si: got %b want 0", nic_si); end
  endtask

  task automatic test_reset_midstream();
    apply_reset(2);
    for (int k = 0; k < 2; k++) begin
      nic_so   = 1'b1;
      nic_do   = {32'hD000 + 32'(k), 31'd0, polarity};
      in_valid = 1'b1;
      in_data  = {32'hE000 + 32'(k), 31'd0, !polarity};
      tick();
    end
    nic_so = 1'b0; in_valid = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || nic_ro !== 1'b0) begin
      n_fail++; $display("FAIL mid_full: got valid=%b ro=%b want valid=1 ro=0", out_valid, nic_ro);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_out_valid: got %b want 0", out_valid); end
    n_chk++;
    if (out_data !== 64'd0) begin n_fail++; $display("FAIL mid_async_out_data: got %h want 0", out_data); end
    n_chk++;
    if (nic_si !== 1'b0 || nic_di !== 64'd0) begin
      n_fail++; $display("FAIL mid_async_nic: got si=%b di=%h want 0", nic_si, nic_di);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1; nic_ri = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = {32'hF000, 31'd0, !polarity};
      #1;
      n_chk++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_out: got %b want 0", out_valid); end
      n_chk++;
      if (nic_si !== 1'b0) begin n_fail++; $display("FAIL mid_stale_nic: got %b want 0", nic_si); end
      n_chk++;
      if (nic_ro !== 1'b1 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL mid_empty: got ro=%b in_ready=%b want 1 1", nic_ro, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back(input int ncyc);
    logic ir;
    apply_reset(2);
    for (int c = 0; c < ncyc; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      nic_ri    = 1'($urandom_range(0, 1));
      nic_so    = m_ro() && ($urandom_range(0, 2) != 0);
      nic_do    = {$urandom, 31'($urandom), polarity};
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, 31'($urandom), 1'($urandom_range(0, 1))};
      if (c == ncyc / 2) nic_so = 1'b1;
      #1;
      ir = m_ir();
      n_chk++;
      if (nic_ro !== m_ro() || in_ready !== ir) begin
        n_fail++; $display("FAIL b2b_ready: got ro=%b ir=%b want ro=%b ir=%b", nic_ro, in_ready, m_ro(), ir);
      end
      n_chk++;
      if (out_valid !== (iq[!polarity].size() != 0)) begin
        n_fail++; $display("FAIL b2b_out_valid: got %b want %b", out_valid, iq[!polarity].size() != 0);
      end
      if (iq[!polarity].size() != 0) begin
        n_chk++;
        if (out_data !== iq[!polarity][0]) begin
          n_fail++; $display("FAIL b2b_out_data: got %h want %h", out_data, iq[!polarity][0]);
        end
      end
      n_chk++;
      if (nic_si !== exp_si || nic_di !== exp_di) begin
        n_fail++; $display("FAIL b2b_nic: got si=%b di=%h want si=%b di=%h", nic_si, nic_di, exp_si, exp_di);
      end
      n_chk++;
      if (proto_err !== exp_perr) begin
        n_fail++; $display("FAIL b2b_proto_err: got %b want %b", proto_err, exp_perr);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ingress_stream(10000);
    test_ingress_stall();
    test_vc_mismatch();
    test_egress_stream(10000);
    test_nic_backpressure();
    test_reset_midstream();
    test_back_to_back(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
